// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter: both requester ports,
// the shared memory port and the owner observability signal.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
) ();
    logic             M0Req;
    logic             M0Write;
    logic [1:0]       M0ByteAccess;
    logic [WIDTH-1:0] M0Adr;
    logic [WIDTH-1:0] M0WData;
    logic             M0Done;
    logic             M0Err;
    logic [WIDTH-1:0] M0RData;

    logic             M1Req;
    logic             M1Write;
    logic [1:0]       M1ByteAccess;
    logic [WIDTH-1:0] M1Adr;
    logic [WIDTH-1:0] M1WData;
    logic             M1Done;
    logic             M1Err;
    logic [WIDTH-1:0] M1RData;

    logic             MemReq;
    logic             MemWrite;
    logic [1:0]       MemByteAccess;
    logic [WIDTH-1:0] MemAdr;
    logic [WIDTH-1:0] MemWData;
    logic [WIDTH-1:0] MemRData;
    logic             MemReady;

    logic             Owner;

    // Arbiter side
    modport slave (
        input  M0Req, M0Write, M0ByteAccess, M0Adr, M0WData,
        input  M1Req, M1Write, M1ByteAccess, M1Adr, M1WData,
        input  MemRData, MemReady,
        output M0Done, M0Err, M0RData,
        output M1Done, M1Err, M1RData,
        output MemReq, MemWrite, MemByteAccess, MemAdr, MemWData,
        output Owner
    );

    // Requester / memory model side
    modport master (
        output M0Req, M0Write, M0ByteAccess, M0Adr, M0WData,
        output M1Req, M1Write, M1ByteAccess, M1Adr, M1WData,
        output MemRData, MemReady,
        input  M0Done, M0Err, M0RData,
        input  M1Done, M1Err, M1RData,
        input  MemReq, MemWrite, MemByteAccess, MemAdr, MemWData,
        input  Owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two blocking
// requesters. A granted request is latched, driven onto the memory port
// until MemReady (or timeout), then answered with a one-cycle Done.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          Reset,
    mem_arbiter_if.slave  bus
);

    localparam int             CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_MAX    = CW'(TIMEOUT);
    localparam bit             TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_q;
    logic             owner_q;
    logic             last_owner_q;
    logic [CW-1:0]    cnt_q;
    logic             write_q;
    logic [1:0]       ba_q;
    logic [WIDTH-1:0] adr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             mem_req_q;
    logic             mem_write_q;
    logic             done0_q;
    logic             done1_q;
    logic             err0_q;
    logic             err1_q;
    logic [WIDTH-1:0] rdata0_q;
    logic [WIDTH-1:0] rdata1_q;

    logic             grant_valid_s;
    logic             grant_id_s;
    logic             win_write_s;
    logic [1:0]       win_ba_s;
    logic [WIDTH-1:0] win_adr_s;
    logic [WIDTH-1:0] win_wdata_s;

    // Round-robin pick: on contention the requester that did not win last time goes next
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (bus.M0Req && bus.M1Req) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_owner_q;
        end else if (bus.M0Req) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (bus.M1Req) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Select the winner's request fields for latching
    always_comb begin
        win_write_s = bus.M0Write;
        win_ba_s    = bus.M0ByteAccess;
        win_adr_s   = bus.M0Adr;
        win_wdata_s = bus.M0WData;
        if (grant_id_s) begin
            win_write_s = bus.M1Write;
            win_ba_s    = bus.M1ByteAccess;
            win_adr_s   = bus.M1Adr;
            win_wdata_s = bus.M1WData;
        end else begin
            win_write_s = bus.M0Write;
            win_ba_s    = bus.M0ByteAccess;
            win_adr_s   = bus.M0Adr;
            win_wdata_s = bus.M0WData;
        end
    end

    // Arbitration FSM with all bus and response outputs registered
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            ba_q         <= 2'b00;
            adr_q        <= '0;
            wdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            // Done/Err are single-cycle pulses unless set below
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_q      <= grant_id_s;
                        last_owner_q <= grant_id_s;
                        write_q      <= win_write_s;
                        ba_q         <= win_ba_s;
                        adr_q        <= win_adr_s;
                        wdata_q      <= win_wdata_s;
                        cnt_q        <= '0;
                        mem_req_q    <= 1'b1;
                        mem_write_q  <= win_write_s;
                        state_q      <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (bus.MemReady) begin
                        // Completion wins over a coincident timeout; stores keep RData
                        if (!write_q) begin
                            if (owner_q) begin
                                rdata1_q <= bus.MemRData;
                            end else begin
                                rdata0_q <= bus.MemRData;
                            end
                        end else begin
                            rdata0_q <= rdata0_q;
                        end
                        done0_q     <= ~owner_q;
                        done1_q     <= owner_q;
                        mem_req_q   <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= RESP;
                    end else if (TIMEOUT_EN && (cnt_q == CNT_MAX)) begin
                        if (owner_q) begin
                            rdata1_q <= '0;
                        end else begin
                            rdata0_q <= '0;
                        end
                        done0_q     <= ~owner_q;
                        done1_q     <= owner_q;
                        err0_q      <= ~owner_q;
                        err1_q      <= owner_q;
                        mem_req_q   <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        // Saturating wait counter
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CW'(1);
                        end else begin
                            cnt_q <= cnt_q;
                        end
                        state_q <= ACCESS;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    mem_req_q   <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.MemReq        = mem_req_q;
    assign bus.MemWrite      = mem_write_q;
    assign bus.MemByteAccess = ba_q;
    assign bus.MemAdr        = adr_q;
    assign bus.MemWData      = wdata_q;
    assign bus.M0Done        = done0_q;
    assign bus.M1Done        = done1_q;
    assign bus.M0Err         = err0_q;
    assign bus.M1Err         = err1_q;
    assign bus.M0RData       = rdata0_q;
    assign bus.M1RData       = rdata1_q;
    assign bus.Owner         = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: requesters push expected
// responses at issue time; a negedge monitor checks grants, the memory
// port and responses against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int TO = 15;

    typedef struct {
        logic        write;
        logic [1:0]  ba;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } txn_t;

    logic CLK;
    logic Reset;
    mem_arbiter_if #(.WIDTH(32)) ifc ();

    mem_arbiter #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (ifc.slave)
    );

    int          checks = 0;
    int          errors = 0;
    txn_t        q0[$];
    txn_t        q1[$];
    int          stall_tab [logic [31:0]];
    logic [31:0] model_rd [2];
    int          seq [2];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int rand_stall();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            6:       return TO;
            7:       return TO + 1;
            8:       return TO - 1;
            9:       return 25;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    // Issue one access: compute expected response from the spec rules, push it, raise Req
    task automatic issue(input int id, input logic w, input logic [1:0] ba,
                         input logic [31:0] wd, input int stall);
        txn_t        t;
        logic [31:0] a;
        seq[id]++;
        a = {id[0], 15'(seq[id]), 16'($urandom)};
        stall_tab[a] = stall;
        t.write  = w;
        t.ba     = ba;
        t.adr    = a;
        t.wdata  = wd;
        t.err    = (stall > TO);
        t.cycles = t.err ? (TO + 1) : (stall + 1);
        if (t.err)  t.rdata = 32'h0;
        else if (w) t.rdata = model_rd[id];
        else        t.rdata = memval(a);
        model_rd[id] = t.rdata;
        if (id == 0) begin
            q0.push_back(t);
            ifc.M0Write = w; ifc.M0ByteAccess = ba; ifc.M0Adr = a; ifc.M0WData = wd; ifc.M0Req = 1'b1;
        end else begin
            q1.push_back(t);
            ifc.M1Write = w; ifc.M1ByteAccess = ba; ifc.M1Adr = a; ifc.M1WData = wd; ifc.M1Req = 1'b1;
        end
    endtask

    task automatic set_req(input int id, input logic v);
        if (id == 0) ifc.M0Req = v;
        else         ifc.M1Req = v;
    endtask

    // Disturb a granted requester's inputs; the arbiter must ignore them
    task automatic scramble(input int id);
        if (id == 0) begin
            ifc.M0Adr = $urandom; ifc.M0WData = $urandom; ifc.M0Write = 1'($urandom); ifc.M0ByteAccess = 2'($urandom);
        end else begin
            ifc.M1Adr = $urandom; ifc.M1WData = $urandom; ifc.M1Write = 1'($urandom); ifc.M1ByteAccess = 2'($urandom);
        end
    endtask

    task automatic wait_done(input int id);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            @(posedge CLK); #2;
            n++;
            if ((id == 0) ? ifc.M0Done : ifc.M1Done) got = 1'b1;
            else if (ifc.MemReq && (ifc.Owner == id[0]) && ($urandom_range(0, 1) == 1)) scramble(id);
        end
        if (!got) chk("done_wait_expired", 32'(n), 32'd0);
    endtask

    task automatic run_drv(input int id, input int n, input bit directed);
        for (int i = 0; i < n; i++) begin
            if (!directed && ($urandom_range(0, 2) == 0)) begin
                set_req(id, 1'b0);
                repeat ($urandom_range(1, 4)) @(posedge CLK);
                #2;
            end
            issue(id, directed ? 1'b0 : 1'($urandom), 2'($urandom), $urandom,
                  directed ? 0 : rand_stall());
            wait_done(id);
        end
        set_req(id, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_memreq"},   32'({ifc.MemReq, ifc.MemWrite}), 32'd0);
        chk({tag, "_done_err"}, 32'({ifc.M0Done, ifc.M1Done, ifc.M0Err, ifc.M1Err}), 32'd0);
        chk({tag, "_rdata0"},   ifc.M0RData, 32'd0);
        chk({tag, "_rdata1"},   ifc.M1RData, 32'd0);
        chk({tag, "_owner_ba"}, 32'({ifc.Owner, ifc.MemByteAccess}), 32'd0);
        chk({tag, "_memadr"},   ifc.MemAdr, 32'd0);
        chk({tag, "_memwdata"}, ifc.MemWData, 32'd0);
    endtask

    // Memory model: per-address stall count, then ready with the address-derived word
    initial begin
        int acc;
        int st;
        acc = 0;
        st = 0;
        ifc.MemReady = 1'b0;
        ifc.MemRData = 32'h0;
        forever begin
            @(posedge CLK); #2;
            if (!Reset) begin
                acc = 0;
                ifc.MemReady = 1'b0;
            end else if (ifc.MemReq) begin
                acc++;
                if (acc == 1) st = stall_tab.exists(ifc.MemAdr) ? stall_tab[ifc.MemAdr] : 0;
                ifc.MemReady = (acc == st + 1);
                ifc.MemRData = ifc.MemReady ? memval(ifc.MemAdr) : $urandom;
            end else begin
                acc = 0;
                ifc.MemReady = 1'($urandom);
                ifc.MemRData = $urandom;
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge
    initial begin
        bit          prev_r0, prev_r1, prev_mreq, prev_done, in_acc;
        bit          model_last, model_owner, exp_w;
        int          acc_n;
        txn_t        cur, t;
        logic [31:0] shown_rd [2];
        prev_r0 = 0; prev_r1 = 0; prev_mreq = 0; prev_done = 0; in_acc = 0;
        model_last = 1; model_owner = 0; exp_w = 0; acc_n = 0;
        shown_rd[0] = 0; shown_rd[1] = 0;
        forever begin
            @(negedge CLK);
            if (!Reset) begin
                model_last = 1'b1; in_acc = 0; acc_n = 0;
                prev_r0 = 0; prev_r1 = 0; prev_mreq = 0; prev_done = 0;
                shown_rd[0] = 32'h0; shown_rd[1] = 32'h0;
            end else begin
                if (ifc.MemWrite && !ifc.MemReq) chk("memwrite_without_memreq", 32'd1, 32'd0);
                if (ifc.MemReq && !prev_mreq) begin
                    if (!prev_r0 && !prev_r1) begin
                        chk("grant_without_request", 32'd1, 32'd0);
                    end else begin
                        exp_w = (prev_r0 && prev_r1) ? ~model_last : (prev_r0 ? 1'b0 : 1'b1);
                        model_last  = exp_w;
                        model_owner = exp_w;
                        chk("grant_owner", 32'(ifc.Owner), 32'(exp_w));
                        if ((exp_w ? q1.size() : q0.size()) == 0) begin
                            chk("grant_no_pending_txn", 32'd1, 32'd0);
                        end else begin
                            cur = exp_w ? q1[0] : q0[0];
                            in_acc = 1;
                            acc_n = 0;
                        end
                    end
                end
                if (ifc.MemReq && in_acc) begin
                    acc_n++;
                    chk("mem_adr",   ifc.MemAdr, cur.adr);
                    chk("mem_wdata", ifc.MemWData, cur.wdata);
                    chk("mem_write_ba", 32'({ifc.MemWrite, ifc.MemByteAccess}), 32'({cur.write, cur.ba}));
                end
                if (ifc.M0Done || ifc.M1Done) begin
                    if (ifc.M0Done && ifc.M1Done) begin
                        chk("both_done", 32'd1, 32'd0);
                    end else if (!in_acc) begin
                        chk("done_without_access", 32'd1, 32'd0);
                    end else begin
                        chk("done_owner", 32'(ifc.M1Done), 32'(model_owner));
                        chk("done_pulse_width", 32'(prev_done), 32'd0);
                        chk("done_memreq_low", 32'(ifc.MemReq), 32'd0);
                        t = model_owner ? q1.pop_front() : q0.pop_front();
                        chk("access_cycles", 32'(acc_n), 32'(t.cycles));
                        chk("err", 32'(model_owner ? ifc.M1Err : ifc.M0Err), 32'(t.err));
                        chk("rdata", model_owner ? ifc.M1RData : ifc.M0RData, t.rdata);
                        shown_rd[model_owner] = t.rdata;
                        chk("other_rdata_held", model_owner ? ifc.M0RData : ifc.M1RData,
                            shown_rd[~model_owner]);
                        in_acc = 0;
                    end
                end else begin
                    chk("err_without_done", 32'({ifc.M0Err, ifc.M1Err}), 32'd0);
                end
                prev_done = ifc.M0Done | ifc.M1Done;
                prev_mreq = ifc.MemReq;
                prev_r0   = ifc.M0Req;
                prev_r1   = ifc.M1Req;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset = 1'b1;
        ifc.M0Req = 0; ifc.M0Write = 0; ifc.M0ByteAccess = 0; ifc.M0Adr = 0; ifc.M0WData = 0;
        ifc.M1Req = 0; ifc.M1Write = 0; ifc.M1ByteAccess = 0; ifc.M1Adr = 0; ifc.M1WData = 0;
        model_rd[0] = 0; model_rd[1] = 0; seq[0] = 0; seq[1] = 0;
        #3 Reset = 1'b0;
        #1 check_reset_vals("por");
        repeat (3) @(posedge CLK);
        #2 Reset = 1'b1;

        // Continuous contention straight out of reset: M0, M1, M0, M1
        fork
            run_drv(0, 2, 1'b1);
            run_drv(1, 2, 1'b1);
        join
        @(posedge CLK); #2;

        // Randomized traffic with wait states, timeouts and idle gaps
        fork
            run_drv(0, 30, 1'b0);
            run_drv(1, 30, 1'b0);
        join
        repeat (3) @(posedge CLK);
        #2;

        // Reset in the middle of a long access
        issue(0, 1'b0, 2'b00, 32'h0, 40);
        n = 0;
        while (!ifc.MemReq && n < 20) begin
            @(posedge CLK); #2;
            n++;
        end
        chk("midreset_access_started", 32'(ifc.MemReq), 32'd1);
        repeat (3) @(posedge CLK);
        #4 Reset = 1'b0;
        #1 check_reset_vals("midreset");
        q0.delete();
        q1.delete();
        model_rd[0] = 0;
        model_rd[1] = 0;
        ifc.M0Req = 1'b0;
        repeat (2) @(posedge CLK);
        #2 Reset = 1'b1;
        @(posedge CLK); #2;
        fork
            run_drv(0, 1, 1'b1);
            run_drv(1, 1, 1'b1);
        join
        repeat (4) @(posedge CLK);
        chk("leftover_txns", 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
